fifo_wr_arbiter: RTL and testbench

- Round-robin arbiter that shares the asy_fifo write port (wr_data, wr_en, fifo_Full) among NREQ requesters in the write clock domain.
- Each grant is held for a burst of up to BURST words, so consecutive words from one source stay contiguous in the FIFO.
- Per-requester valid/ready handshake; the block never writes while fifo_Full is high.

---
 rtl/fifo_wr_arbiter.sv | 117 +++++++++++
 tb/tb_fifo_wr_arbiter.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_wr_arbiter.sv
// Round-robin, burst-holding arbiter in front of a FIFO write port.
// FIFO_ARB_PRIO0_EN: requester 0 always wins in IDLE; round-robin covers 1..NREQ-1.
module fifo_wr_arbiter #(
  parameter int N     = 8,
  parameter int NREQ  = 4,
  parameter int BURST = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NREQ-1:0]     req_valid,
  input  logic [NREQ*N-1:0]   req_data,
  output logic [NREQ-1:0]     req_ready,
  input  logic                fifo_Full,
  output logic [N-1:0]        wr_data,
  output logic                wr_en,
  output logic [NREQ-1:0]     grant,
  output logic                busy
);

  localparam int IDW = $clog2(NREQ);
  localparam int BW  = $clog2(BURST) + 1;

  typedef enum logic {IDLE, GRANT} state_t;

  state_t          state_q, state_d;
  logic [NREQ-1:0] grant_q, grant_d;
  logic [IDW-1:0]  id_q, id_d;
  logic [IDW-1:0]  last_q, last_d;
  logic [BW-1:0]   beat_q, beat_d;
  logic [IDW:0]    pick_res;

  // Returns {found, index}: first valid requester searching upward from last+1.
  function automatic logic [IDW:0] pick(input logic [NREQ-1:0] v,
                                        input logic [IDW-1:0]  last);
    logic           found;
    logic [IDW-1:0] idx;
    logic           allow;
    int             j;
    found = 1'b0;
    idx   = '0;
    for (int k = 1; k <= NREQ; k++) begin
      j     = (int'(last) + k) % NREQ;
      allow = v[j];
`ifdef FIFO_ARB_PRIO0_EN
      if (j == 0) allow = 1'b0;
`endif
      if (!found && allow) begin
        found = 1'b1;
        idx   = IDW'(j);
      end
    end
`ifdef FIFO_ARB_PRIO0_EN
    if (v[0]) begin
      found = 1'b1;
      idx   = '0;
    end
`endif
    return {found, idx};
  endfunction

  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    id_d      = id_q;
    last_d    = last_q;
    beat_d    = beat_q;
    req_ready = '0;
    wr_en     = 1'b0;
    wr_data   = '0;
    busy      = 1'b0;
    pick_res  = pick(req_valid, last_q);
    case (state_q)
      IDLE: begin
        beat_d = '0;
        if (pick_res[IDW]) begin
          state_d = GRANT;
          id_d    = pick_res[IDW-1:0];
          grant_d = NREQ'(1) << pick_res[IDW-1:0];
        end
      end
      GRANT: begin
        busy             = 1'b1;
        req_ready[id_q]  = ~fifo_Full;
        wr_data          = req_data[int'(id_q)*N +: N];
        wr_en            = req_valid[id_q] & ~fifo_Full;
        if (wr_en) beat_d = beat_q + BW'(1);
        // Release on the last beat of a burst, or as soon as the owner goes idle.
        if (!req_valid[id_q] || (wr_en && beat_q == BW'(BURST - 1))) begin
          state_d = IDLE;
          last_d  = id_q;
          grant_d = '0;
          beat_d  = '0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      grant_q <= '0;
      id_q    <= '0;
      last_q  <= IDW'(NREQ - 1);
      beat_q  <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      id_q    <= id_d;
      last_q  <= last_d;
      beat_q  <= beat_d;
    end
  end

  assign grant = grant_q;

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Scoreboard bench for fifo_wr_arbiter: expected FIFO writes are queued as
// stimulus is applied and popped whenever wr_en is seen.
module tb_fifo_wr_arbiter;

  localparam int N     = 8;
  localparam int NREQ  = 4;
  localparam int BURST = 4;

  logic              clk = 1'b0;
  logic              rst;
  logic [NREQ-1:0]   req_valid;
  logic [NREQ*N-1:0] req_data;
  logic [NREQ-1:0]   req_ready;
  logic              fifo_Full;
  logic [N-1:0]      wr_data;
  logic              wr_en;
  logic [NREQ-1:0]   grant;
  logic              busy;

  typedef struct packed {
    logic [NREQ-1:0] g;
    logic [N-1:0]    d;
  } entry_t;

  entry_t sb[$];
  int     n_checks = 0;
  int     n_pass   = 0;

  fifo_wr_arbiter #(.N(N), .NREQ(NREQ), .BURST(BURST)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_data  (req_data),
    .req_ready (req_ready),
    .fifo_Full (fifo_Full),
    .wr_data   (wr_data),
    .wr_en     (wr_en),
    .grant     (grant),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
  endtask

  task automatic push(input int id, input int cnt);
    entry_t e;
    for (int k = 0; k < cnt; k++) begin
      e.g = NREQ'(1) << id;
      e.d = req_data[id*N +: N];
      sb.push_back(e);
    end
  endtask

  task automatic set_data(input logic [N-1:0] d0, input logic [N-1:0] d1,
                          input logic [N-1:0] d2, input logic [N-1:0] d3);
    req_data = {d3, d2, d1, d0};
  endtask

  // Sample just after the input change point, well away from posedge.
  task automatic smp();
    entry_t e;
    #1;
    if (fifo_Full) chk("no_wr_full", {31'd0, wr_en}, 32'd0);
    if (wr_en) begin
      if (sb.size() == 0) begin
        chk("sb_unexpected_write", sb.size(), 32'd1);
      end else begin
        e = sb.pop_front();
        chk("wr_data", {24'd0, wr_data}, {24'd0, e.d});
        chk("wr_grant", {28'd0, grant}, {28'd0, e.g});
        chk("ready_owner", {28'd0, req_ready}, {28'd0, e.g});
      end
    end
  endtask

  task automatic nxt();
    @(negedge clk);
  endtask

  task automatic cyc();
    smp();
    nxt();
  endtask

  task automatic do_reset();
    rst       = 1'b1;
    req_valid = '0;
    fifo_Full = 1'b0;
    nxt();
    nxt();
    rst = 1'b0;
  endtask

  initial begin
    rst       = 1'b1;
    req_valid = '0;
    req_data  = '0;
    fifo_Full = 1'b0;

    // Reset state
    #2;
    chk("rst_grant", {28'd0, grant}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_wr_en", {31'd0, wr_en}, 32'd0);
    chk("rst_ready", {28'd0, req_ready}, 32'd0);
    chk("rst_wr_data", {24'd0, wr_data}, 32'd0);
    nxt();
    nxt();
    rst = 1'b0;

    // Single requester: one burst, one bubble, regrant
    set_data(8'h11, 8'h22, 8'h33, 8'h44);
    req_valid = 4'b0001;
    push(0, BURST);
    smp(); chk("t1_latency_grant", {28'd0, grant}, 32'd0); nxt();
    for (int c = 0; c < BURST; c++) begin
      smp(); chk("t1_wr_en", {31'd0, wr_en}, 32'd1); nxt();
    end
    smp();
    chk("t1_bubble_grant", {28'd0, grant}, 32'd0);
    chk("t1_bubble_busy", {31'd0, busy}, 32'd0);
    chk("t1_bubble_wr_en", {31'd0, wr_en}, 32'd0);
    nxt();
    req_valid = 4'b0000;
    smp();
    chk("t1_regrant", {28'd0, grant}, 32'h1);
    chk("t1_regrant_busy", {31'd0, busy}, 32'd1);
    nxt();
    cyc();
    chk("t1_drain", sb.size(), 32'd0);

    // All requesters held: rotating bursts of BURST
    do_reset();
    set_data(8'hA0, 8'hA1, 8'hA2, 8'hA3);
    req_valid = 4'b1111;
    for (int r = 0; r < 2; r++)
      for (int i = 0; i < NREQ; i++)
`ifdef FIFO_ARB_PRIO0_EN
        push(0, BURST);
`else
        push(i, BURST);
`endif
    for (int c = 0; c < 2 * NREQ * (BURST + 1); c++) cyc();
    req_valid = 4'b0000;
    cyc();
    chk("t2_drain", sb.size(), 32'd0);

    // Owner 1 stalled by fifo_Full mid-burst
    set_data(8'h41, 8'h51, 8'h61, 8'h71);
    req_valid = 4'b0010;
    push(1, BURST);
    cyc(); cyc(); cyc();
    fifo_Full = 1'b1;
    for (int c = 0; c < 5; c++) begin
      smp();
      chk("t3_full_ready", {28'd0, req_ready}, 32'd0);
      chk("t3_full_grant", {28'd0, grant}, 32'h2);
      nxt();
    end
    fifo_Full = 1'b0;
    smp(); chk("t3_resume_wr_en", {31'd0, wr_en}, 32'd1); nxt();
    smp(); chk("t3_resume_wr_en", {31'd0, wr_en}, 32'd1); nxt();
    smp(); chk("t3_release_grant", {28'd0, grant}, 32'd0); nxt();
    req_valid = 4'b0000;
    cyc();
    chk("t3_drain", sb.size(), 32'd0);

`ifndef FIFO_ARB_PRIO0_EN
    // Owner 2 goes idle after one word; requester 3 follows
    set_data(8'h10, 8'h20, 8'h30, 8'h40);
    req_valid = 4'b1101;
    push(2, 1);
    cyc();
    cyc();
    req_valid = 4'b1001;
    push(3, BURST);
    smp();
    chk("t4_drop_wr_en", {31'd0, wr_en}, 32'd0);
    chk("t4_drop_grant", {28'd0, grant}, 32'h4);
    nxt();
    smp(); chk("t4_bubble_grant", {28'd0, grant}, 32'd0); nxt();
    smp(); chk("t4_next_grant", {28'd0, grant}, 32'h8); nxt();
    for (int c = 0; c < BURST; c++) cyc();
    req_valid = 4'b0000;
    smp(); chk("t4_wrap_grant", {28'd0, grant}, 32'h1); nxt();
    cyc();
    chk("t4_drain", sb.size(), 32'd0);

    // Reset during the third beat abandons the burst
    set_data(8'h11, 8'h22, 8'h62, 8'h44);
    req_valid = 4'b0101;
    push(2, 2);
    cyc(); cyc(); cyc();
    #1;
    chk("t5_beat3_wr_en", {31'd0, wr_en}, 32'd1);
    chk("t5_beat3_grant", {28'd0, grant}, 32'h4);
    rst = 1'b1;
    #1;
    chk("t5_async_wr_en", {31'd0, wr_en}, 32'd0);
    chk("t5_async_grant", {28'd0, grant}, 32'd0);
    chk("t5_async_busy", {31'd0, busy}, 32'd0);
    nxt();
    rst = 1'b0;
    push(0, 1);
    smp(); chk("t5_idle_grant", {28'd0, grant}, 32'd0); nxt();
    smp(); chk("t5_first_grant", {28'd0, grant}, 32'h1); nxt();
    req_valid = 4'b0000;
    cyc();
    cyc();
    chk("t5_drain", sb.size(), 32'd0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
